aes_main_core: RTL and testbench
================================

Name: aes_main_core

Overview:
- Iterative AES-128 encryption engine: one round per clock, with strobe handshakes on the input and output sides.
- Holds an internal 128-bit long key derived from an 8-bit password. The key has a limited lifetime, after which it must be rotated through a request/accept handshake.
- Sits between a host data source/sink and a transmit path; no clock divider inside (single clock domain).

Parameters:
- INIT_KEY, 128'h000102030405060708090a0b0c0d0e0f, base key seed.
- KEY_LIFETIME, 4, number of blocks encrypted per key before rotation is requested (≥1).

Ports:
- clk_in, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- data_in_stb, input, 1, input block valid.
- data_out_stb, input, 1, consumer has taken data_out.
- data_in, input, 128, plaintext block.
- password, input, 8, key-derivation byte.
- usr_long_key_valid, output, 1, long key loaded and not expired.
- usr_long_key_change_rq, output, 1, key lifetime exhausted; rotation requested.
- usr_long_key_ch, input, 1, user accepts rotation (1-cycle pulse).
- ready, output, 1, block can be accepted this cycle.
- ready_for_transmit, output, 1, engine idle (no computation, no pending output).
- data_out, output, 128, ciphertext.
- data_valid, output, 1, data_out holds an untaken result.

Behaviour:
- Reset (reset=0): all outputs 0; state KEYLOAD; block counter 0; internal state and key registers cleared.
- KEYLOAD (1 cycle): long_key <= INIT_KEY (password mixing per Optional Feature); usr_long_key_valid <= 1; go to IDLE.
- IDLE:
  - ready_for_transmit = 1.
  - ready = usr_long_key_valid & ~usr_long_key_change_rq.
- Block capture:
  - Occurs on an edge where data_in_stb & ready.
  - state <= data_in ^ long_key; round <= 1; counter += 1; ready and ready_for_transmit drop the next cycle.
  - data_in_stb without ready is ignored.
- ROUND (rounds 1..10, one per cycle):
  - Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10: no MixColumns.
  - Round keys are expanded on the fly from long_key, using Rcon 01,02,04,08,10,20,40,80,1b,36.
  - The round-10 key is latched into next_key.
- Latency: data_out and data_valid are set on the 10th edge after the capture edge; then go to DONE.
- DONE:
  - data_out is held stable with data_valid=1.
  - On an edge with data_out_stb=1: data_valid <= 0 and go to IDLE. data_out keeps its value.
  - data_out_stb held high continuously is legal; it completes each block as soon as data_valid is set.
  - No new block is accepted while data_valid=1.
- Key lifetime:
  - When counter == KEY_LIFETIME and state is IDLE: usr_long_key_change_rq <= 1 and usr_long_key_valid <= 0.
  - On an edge with usr_long_key_ch=1 while the request is high: long_key <= next_key; counter <= 0; request <= 0; valid <= 1.
  - usr_long_key_ch with no request pending is ignored.
- Simultaneous events: a key-change request never interrupts a block in flight; it asserts only in IDLE.
- Reset mid-operation aborts the block and the result is discarded.

Optional Feature:
- Macro AES_MAIN_PWD_EN.
- Defined: KEYLOAD computes long_key <= INIT_KEY ^ {16{password}}.
- Undefined: password is ignored (port kept, unused); long_key <= INIT_KEY.

Decomposition:
- Package aes_main_pkg: state enum (KEYLOAD, IDLE, ROUND, DONE), AES_ROUNDS=10, Rcon table, xtime/GF multiply helper functions.
- Sub-module aes_sbox: combinational byte S-box, 8-bit in/out. Instantiated 16× for the state and 4× for key expansion.

Test Plan:
- FIPS-197 vector:
  - Setup: reset, then password=8'h00 (or macro undefined).
  - Stimulus: capture 00112233445566778899aabbccddeeff.
  - Response: data_valid rises 10 cycles after capture; data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Handshake:
  - Stimulus: hold data_out_stb=0.
  - Response: data_valid and data_out stay stable; ready=0 and ready_for_transmit=0 until data_out_stb=1, then ready returns the next cycle.
- Lifetime:
  - Stimulus: encrypt 4 blocks with data_out_stb tied high.
  - Response: after the 4th, usr_long_key_change_rq=1, usr_long_key_valid=0, ready=0; data_in_stb ignored.
- Rotation:
  - Stimulus: pulse usr_long_key_ch.
  - Response: request clears, valid=1, and the internal key equals 13111d7fe3944a17f307a78b4d2b30c5. Next block matches the software model with that key.
- Password:
  - Stimulus: with AES_MAIN_PWD_EN, password=8'haa.
  - Response: ciphertext matches the software model with key INIT_KEY ^ {16{8'haa}}.
- Reset mid-round:
  - Stimulus: assert reset at round 5.
  - Response: all outputs 0 immediately; after release, 1 KEYLOAD cycle, then ready=1.

Source files
------------

// File: rtl/aes_main_pkg.sv
// aes_main_pkg
// Shared definitions for the iterative AES-128 engine:
//   fsm_t      - controller states (KEYLOAD, IDLE, ROUND, DONE)
//   AES_ROUNDS - number of cipher rounds for a 128-bit key
//   rcon       - round constant for key expansion round 1..10
//   xtime      - multiply by x (02) in GF(2^8)
//   gf_mul     - general GF(2^8) multiply (used by the S-box inverse)
//   mix_column - MixColumns on one 32-bit column (row 0 in the MSB)
package aes_main_pkg;

  typedef enum logic [1:0] {
    KEYLOAD = 2'd0,
    IDLE    = 2'd1,
    ROUND   = 2'd2,
    DONE    = 2'd3
  } fsm_t;

  localparam int AES_ROUNDS = 10;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox
// Combinational AES S-box, computed arithmetically rather than from a table:
// multiplicative inverse in GF(2^8) (x^254, so 0 maps to 0) followed by the
// FIPS-197 affine transform.
// Ports:
//   x - input byte
//   s - substituted byte
module aes_sbox
  import aes_main_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] s
);

  logic [7:0] p;
  logic [7:0] inv;

  // Six square-and-multiply steps build x^127; one more square gives x^254.
  always_comb begin
    p = x;
    for (int i = 0; i < 6; i++) begin
      p = gf_mul(gf_mul(p, p), x);
    end
    inv = gf_mul(p, p);
    s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_main_core.sv
// aes_main_core
// Iterative AES-128 encryptor, one round per clock, with an internal long key
// that must be rotated after KEY_LIFETIME blocks.
// Optional feature macro: AES_MAIN_PWD_EN (mix the password byte into the key
// seed at KEYLOAD; when undefined the password port is ignored).
// Ports:
//   clk_in                 - clock, rising edge
//   reset                  - asynchronous active-low reset
//   data_in_stb / data_in  - plaintext block strobe and data
//   data_out_stb           - consumer has taken data_out
//   password               - key-derivation byte
//   usr_long_key_valid     - long key loaded and not expired
//   usr_long_key_change_rq - lifetime exhausted, rotation requested
//   usr_long_key_ch        - rotation accept pulse
//   ready                  - a block can be captured this cycle
//   ready_for_transmit     - engine idle
//   data_out / data_valid  - ciphertext and its untaken flag
module aes_main_core
  import aes_main_pkg::*;
#(
  parameter logic [127:0] INIT_KEY     = 128'h000102030405060708090a0b0c0d0e0f,
  parameter int           KEY_LIFETIME = 4
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         data_in_stb,
  input  logic         data_out_stb,
  input  logic [127:0] data_in,
  input  logic [7:0]   password,
  output logic         usr_long_key_valid,
  output logic         usr_long_key_change_rq,
  input  logic         usr_long_key_ch,
  output logic         ready,
  output logic         ready_for_transmit,
  output logic [127:0] data_out,
  output logic         data_valid
);

  localparam int CW = $clog2(KEY_LIFETIME + 1);

  fsm_t           fsm;
  fsm_t           fsm_next;
  logic [127:0]   aes_state;
  logic [127:0]   rk;
  logic [127:0]   long_key;
  logic [127:0]   next_key;
  logic [3:0]     round;
  logic [CW-1:0]  blk_cnt;
  logic           key_exhausted;
  logic           capture;
  logic           last_round;
  logic [127:0]   key_seed;
  logic [31:0]    rot_word;
  logic [31:0]    sub_word;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   rk_next;
  logic [127:0]   sub_bytes;
  logic [127:0]   shifted;
  logic [127:0]   mixed;
  logic [127:0]   round_out;

`ifdef AES_MAIN_PWD_EN
  assign key_seed = INIT_KEY ^ {16{password}};
`else
  // Password is deliberately masked out so the port stays but has no effect.
  assign key_seed = INIT_KEY ^ {120'd0, password & 8'h00};
`endif

  // The counter term closes the one-cycle gap between the last block
  // returning to IDLE and the change request register setting.
  assign key_exhausted      = (blk_cnt == CW'(KEY_LIFETIME));
  assign ready              = (fsm == IDLE) & usr_long_key_valid &
                              ~usr_long_key_change_rq & ~key_exhausted;
  assign ready_for_transmit = (fsm == IDLE);
  assign capture            = data_in_stb & ready;
  assign last_round         = (round == 4'(AES_ROUNDS));

  // On-the-fly key expansion: rk holds the previous round key.
  assign rot_word = {rk[23:0], rk[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_key_sbox
    aes_sbox u_sbox (
      .x (rot_word[31-8*k -: 8]),
      .s (sub_word[31-8*k -: 8])
    );
  end

  assign n0      = rk[127:96] ^ sub_word ^ {rcon(round), 24'h000000};
  assign n1      = rk[95:64]  ^ n0;
  assign n2      = rk[63:32]  ^ n1;
  assign n3      = rk[31:0]   ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  // Byte i of the state is row i%4, column i/4, byte 0 in the MSBs.
  for (genvar b = 0; b < 16; b++) begin : g_state_sbox
    aes_sbox u_sbox (
      .x (aes_state[127-8*b -: 8]),
      .s (sub_bytes[127-8*b -: 8])
    );
  end

  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(r+4*c) -: 8] = sub_bytes[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
    round_out = (last_round ? shifted : mixed) ^ rk_next;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) fsm <= KEYLOAD;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      KEYLOAD: fsm_next = IDLE;
      IDLE:    if (capture) fsm_next = ROUND;
      ROUND:   if (last_round) fsm_next = DONE;
      DONE:    if (data_out_stb) fsm_next = IDLE;
      default: fsm_next = KEYLOAD;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      aes_state              <= '0;
      rk                     <= '0;
      long_key               <= '0;
      next_key               <= '0;
      round                  <= '0;
      blk_cnt                <= '0;
      usr_long_key_valid     <= 1'b0;
      usr_long_key_change_rq <= 1'b0;
      data_out               <= '0;
      data_valid             <= 1'b0;
    end else begin
      case (fsm)
        KEYLOAD: begin
          long_key           <= key_seed;
          usr_long_key_valid <= 1'b1;
        end
        IDLE: begin
          if (capture) begin
            aes_state <= data_in ^ long_key;
            rk        <= long_key;
            round     <= 4'd1;
            blk_cnt   <= blk_cnt + CW'(1);
          end else if (usr_long_key_change_rq && usr_long_key_ch) begin
            long_key               <= next_key;
            blk_cnt                <= '0;
            usr_long_key_change_rq <= 1'b0;
            usr_long_key_valid     <= 1'b1;
          end else if (key_exhausted && !usr_long_key_change_rq) begin
            usr_long_key_change_rq <= 1'b1;
            usr_long_key_valid     <= 1'b0;
          end
        end
        ROUND: begin
          aes_state <= round_out;
          rk        <= rk_next;
          round     <= round + 4'd1;
          if (last_round) begin
            data_out   <= round_out;
            data_valid <= 1'b1;
            next_key   <= rk_next;
            round      <= 4'd0;
          end
        end
        DONE: begin
          if (data_out_stb) data_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_main_core.sv
// tb_aes_main_core
// Self-checking bench for aes_main_core. A table-driven AES-128 software model
// (S-box generated by the 3 / 3^-1 generator walk) produces expected
// ciphertexts, which are queued at capture time and popped when data_valid rises.
module tb_aes_main_core;

  localparam logic [127:0] INIT_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk_in = 1'b0;
  logic         reset = 1'b1;
  logic         data_in_stb = 1'b0;
  logic         data_out_stb = 1'b0;
  logic [127:0] data_in = '0;
  logic [7:0]   password = 8'h00;
  logic         usr_long_key_ch = 1'b0;
  logic         usr_long_key_valid;
  logic         usr_long_key_change_rq;
  logic         ready;
  logic         ready_for_transmit;
  logic [127:0] data_out;
  logic         data_valid;

  aes_main_core #(.INIT_KEY(INIT_KEY), .KEY_LIFETIME(4)) dut (
    .clk_in                 (clk_in),
    .reset                  (reset),
    .data_in_stb            (data_in_stb),
    .data_out_stb           (data_out_stb),
    .data_in                (data_in),
    .password               (password),
    .usr_long_key_valid     (usr_long_key_valid),
    .usr_long_key_change_rq (usr_long_key_change_rq),
    .usr_long_key_ch        (usr_long_key_ch),
    .ready                  (ready),
    .ready_for_transmit     (ready_for_transmit),
    .data_out               (data_out),
    .data_valid             (data_valid)
  );

  always #5 clk_in = ~clk_in;

  int           pass_cnt = 0;
  int           total_cnt = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_q [$];
  logic [127:0] cur_key;
  logic [127:0] next_key_m;

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] seed_key(input logic [7:0] pwd);
`ifdef AES_MAIN_PWD_EN
    return INIT_KEY ^ {16{pwd}};
`else
    return INIT_KEY ^ {120'd0, pwd & 8'h00};
`endif
  endfunction

  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  task automatic model_aes(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output logic [127:0] lastk);
    logic [7:0] st [16];
    logic [7:0] k  [16];
    logic [7:0] t  [16];
    logic [7:0] tw [4];
    logic [7:0] rc;
    logic [7:0] a0, a1, a2, a3, all;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i]  = key[127-8*i -: 8];
      st[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      tw[0] = sbox_t[k[13]] ^ rc;
      tw[1] = sbox_t[k[14]];
      tw[2] = sbox_t[k[15]];
      tw[3] = sbox_t[k[12]];
      for (int i = 0; i < 4; i++)  k[i] = k[i] ^ tw[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = m2(rc);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sbox_t[st[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          all = a0 ^ a1 ^ a2 ^ a3;
          st[4*c]   = a0 ^ all ^ m2(a0 ^ a1);
          st[4*c+1] = a1 ^ all ^ m2(a1 ^ a2);
          st[4*c+2] = a2 ^ all ^ m2(a2 ^ a3);
          st[4*c+3] = a3 ^ all ^ m2(a3 ^ a0);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) begin
      ct[127-8*i -: 8]    = st[i];
      lastk[127-8*i -: 8] = k[i];
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Captures one block with the current key and checks latency and ciphertext.
  task automatic send_block(input logic [127:0] pt);
    logic [127:0] ct, lk, exp_ct;
    int lat;
    model_aes(cur_key, pt, ct, lk);
    next_key_m = lk;
    exp_q.push_back(ct);
    total_cnt++;
    if (ready !== 1'b1) $display("[TB] FAIL ready_before_capture: got %b expected 1", ready);
    else pass_cnt++;
    data_in = pt;
    data_in_stb = 1'b1;
    tick();
    data_in_stb = 1'b0;
    total_cnt++;
    if ({ready, ready_for_transmit} !== 2'b00)
      $display("[TB] FAIL busy_after_capture: got %b expected 00", {ready, ready_for_transmit});
    else pass_cnt++;
    lat = 0;
    while (data_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    total_cnt++;
    if (lat !== 10) $display("[TB] FAIL latency: got %0d expected 10", lat);
    else pass_cnt++;
    exp_ct = exp_q.pop_front();
    total_cnt++;
    if (data_out !== exp_ct) $display("[TB] FAIL ciphertext: got %h expected %h", data_out, exp_ct);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({usr_long_key_valid, usr_long_key_change_rq, ready, ready_for_transmit, data_valid} !== 5'b0 ||
        data_out !== '0)
      $display("[TB] FAIL reset_outputs: got %b/%h expected 00000/0",
               {usr_long_key_valid, usr_long_key_change_rq, ready, ready_for_transmit, data_valid}, data_out);
    else pass_cnt++;
    cur_key = seed_key(password);
    reset = 1'b1;
    total_cnt++;
    if (ready !== 1'b0) $display("[TB] FAIL keyload_ready: got %b expected 0", ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({usr_long_key_valid, usr_long_key_change_rq, ready, ready_for_transmit} !== 4'b1011)
      $display("[TB] FAIL after_keyload: got %b expected 1011",
               {usr_long_key_valid, usr_long_key_change_rq, ready, ready_for_transmit});
    else pass_cnt++;
    total_cnt++;
    if (dut.long_key !== cur_key) $display("[TB] FAIL init_key: got %h expected %h", dut.long_key, cur_key);
    else pass_cnt++;
  endtask

  task automatic test_fips;
    send_block(128'h00112233445566778899aabbccddeeff);
    total_cnt++;
    if (data_out !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
      $display("[TB] FAIL fips_vector: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", data_out);
    else pass_cnt++;
  endtask

  task automatic test_handshake;
    logic [127:0] hold;
    hold = data_out;
    for (int i = 0; i < 4; i++) begin
      data_in = 128'hdeadbeef_00000000_00000000_00000000 + 128'(i);
      data_in_stb = 1'b1;
      tick();
      total_cnt++;
      if (data_valid !== 1'b1 || data_out !== hold || ready !== 1'b0 || ready_for_transmit !== 1'b0)
        $display("[TB] FAIL hold_done: got v=%b r=%b t=%b %h expected v=1 r=0 t=0 %h",
                 data_valid, ready, ready_for_transmit, data_out, hold);
      else pass_cnt++;
    end
    data_in_stb = 1'b0;
    data_out_stb = 1'b1;
    tick();
    data_out_stb = 1'b0;
    total_cnt++;
    if (data_valid !== 1'b0 || data_out !== hold || ready !== 1'b1 || ready_for_transmit !== 1'b1)
      $display("[TB] FAIL release_done: got v=%b r=%b t=%b %h expected v=0 r=1 t=1 %h",
               data_valid, ready, ready_for_transmit, data_out, hold);
    else pass_cnt++;
  endtask

  task automatic test_ignored_change;
    usr_long_key_ch = 1'b1;
    tick();
    usr_long_key_ch = 1'b0;
    total_cnt++;
    if (usr_long_key_change_rq !== 1'b0 || usr_long_key_valid !== 1'b1 || dut.long_key !== cur_key)
      $display("[TB] FAIL stray_key_ch: got rq=%b v=%b %h expected rq=0 v=1 %h",
               usr_long_key_change_rq, usr_long_key_valid, dut.long_key, cur_key);
    else pass_cnt++;
  endtask

  task automatic test_lifetime;
    data_out_stb = 1'b1;
    for (int b = 0; b < 3; b++) begin
      send_block({$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    tick();
    total_cnt++;
    if ({usr_long_key_change_rq, usr_long_key_valid, ready} !== 3'b100)
      $display("[TB] FAIL lifetime_request: got %b expected 100",
               {usr_long_key_change_rq, usr_long_key_valid, ready});
    else pass_cnt++;
    data_in_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (ready_for_transmit !== 1'b1 || data_valid !== 1'b0 || usr_long_key_change_rq !== 1'b1)
        $display("[TB] FAIL expired_ignore: got t=%b v=%b rq=%b expected t=1 v=0 rq=1",
                 ready_for_transmit, data_valid, usr_long_key_change_rq);
      else pass_cnt++;
    end
    data_in_stb = 1'b0;
  endtask

  task automatic test_rotation;
    usr_long_key_ch = 1'b1;
    tick();
    usr_long_key_ch = 1'b0;
    total_cnt++;
    if ({usr_long_key_change_rq, usr_long_key_valid, ready} !== 3'b011)
      $display("[TB] FAIL rotation_flags: got %b expected 011",
               {usr_long_key_change_rq, usr_long_key_valid, ready});
    else pass_cnt++;
    total_cnt++;
    if (dut.long_key !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
      $display("[TB] FAIL rotated_key_const: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", dut.long_key);
    else pass_cnt++;
    total_cnt++;
    if (dut.long_key !== next_key_m)
      $display("[TB] FAIL rotated_key_model: got %h expected %h", dut.long_key, next_key_m);
    else pass_cnt++;
    cur_key = next_key_m;
    send_block(128'h3243f6a8885a308d313198a2e0370734);
    tick();
  endtask

  task automatic test_password;
    password = 8'haa;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cur_key = seed_key(8'haa);
    tick();
    total_cnt++;
    if (dut.long_key !== cur_key) $display("[TB] FAIL password_key: got %h expected %h", dut.long_key, cur_key);
    else pass_cnt++;
    send_block(128'h00112233445566778899aabbccddeeff);
    tick();
  endtask

  task automatic test_reset_mid_round;
    data_in = 128'hffeeddccbbaa99887766554433221100;
    data_in_stb = 1'b1;
    tick();
    data_in_stb = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({usr_long_key_valid, usr_long_key_change_rq, ready, ready_for_transmit, data_valid} !== 5'b0 ||
        data_out !== '0)
      $display("[TB] FAIL midround_reset: got %b/%h expected 00000/0",
               {usr_long_key_valid, usr_long_key_change_rq, ready, ready_for_transmit, data_valid}, data_out);
    else pass_cnt++;
    reset = 1'b1;
    total_cnt++;
    if (ready !== 1'b0) $display("[TB] FAIL midround_keyload: got %b expected 0", ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ready !== 1'b1 || usr_long_key_valid !== 1'b1)
      $display("[TB] FAIL midround_recover: got r=%b v=%b expected r=1 v=1", ready, usr_long_key_valid);
    else pass_cnt++;
    send_block(128'h0123456789abcdef0123456789abcdef);
    tick();
    total_cnt++;
    if (exp_q.size() !== 0) $display("[TB] FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_handshake();
    test_ignored_change();
    test_lifetime();
    test_rotation();
    test_password();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
